// File: rtl/rst_sequencer.sv
// Reset sequencer: synchronises board reset release, then drops one reset output per
// STAGE_DLY cycles (stage 0 first). Supports a software reset pulse and a hold input.
module rst_sequencer #(
   parameter int NUM_STAGES = 3,
   parameter int SYNC_DEPTH = 2,
   parameter int STAGE_DLY  = 4,
   parameter int SW_PULSE   = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  sw_rst_req_i,
   input  logic                  hold_i,
   output logic [NUM_STAGES-1:0] rst_o,
   output logic                  busy_o,
   output logic                  done_o,
   output logic [1:0]            state_o
);

   localparam int CNT_MAX = (STAGE_DLY > SW_PULSE) ? STAGE_DLY : SW_PULSE;
   localparam int CNT_W   = $clog2(CNT_MAX) + 1;
   localparam int IDX_W   = $clog2(NUM_STAGES) + 1;

   localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(STAGE_DLY - 1);
   localparam logic [CNT_W-1:0] SW_LAST  = CNT_W'(SW_PULSE - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_STAGES - 1);

   typedef enum logic [1:0] {
      ASSERT  = 2'd0,
      RELEASE = 2'd1,
      RUN     = 2'd2,
      SWRST   = 2'd3
   } state_t;

   state_t                  state_q;
   logic [CNT_W-1:0]        cnt_q;
   logic [IDX_W-1:0]        idx_q;
   logic [NUM_STAGES-1:0]   rst_q;
   logic                    done_q;
   logic [SYNC_DEPTH-1:0]   sync_q;
   logic                    rst_clean;

   // Board reset is only trusted once a 1 has walked through the whole chain.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_DEPTH-2:0], 1'b1};
      end
   end

   assign rst_clean = sync_q[SYNC_DEPTH-1];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ASSERT;
         cnt_q   <= '0;
         idx_q   <= '0;
         rst_q   <= '1;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            ASSERT: begin
               rst_q <= '1;
               if (rst_clean && !hold_i) begin
                  state_q <= RELEASE;
                  cnt_q   <= '0;
                  idx_q   <= '0;
               end
            end
            RELEASE: begin
               if (sw_rst_req_i) begin
                  // A request on the final-release edge beats the done pulse.
                  rst_q   <= '1;
                  state_q <= SWRST;
                  cnt_q   <= '0;
               end else if (!hold_i) begin
                  if (cnt_q == DLY_LAST) begin
                     cnt_q <= '0;
                     idx_q <= idx_q + IDX_W'(1);
                     for (int k = 0; k < NUM_STAGES; k++) begin
                        if (idx_q == IDX_W'(k)) begin
                           rst_q[k] <= 1'b0;
                        end
                     end
                     if (idx_q == IDX_LAST) begin
                        state_q <= RUN;
                        done_q  <= 1'b1;
                     end
                  end else begin
                     cnt_q <= cnt_q + CNT_W'(1);
                  end
               end
            end
            RUN: begin
               rst_q <= '0;
               if (sw_rst_req_i) begin
                  rst_q   <= '1;
                  state_q <= SWRST;
                  cnt_q   <= '0;
               end
            end
            SWRST: begin
               rst_q <= '1;
               if (sw_rst_req_i) begin
                  cnt_q <= '0;
               end else if (cnt_q == SW_LAST) begin
                  state_q <= RELEASE;
                  cnt_q   <= '0;
                  idx_q   <= '0;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            default: begin
               state_q <= ASSERT;
               rst_q   <= '1;
            end
         endcase
      end
   end

   assign rst_o   = rst_q;
   assign done_o  = done_q;
   assign state_o = state_q;
   assign busy_o  = (state_q != RUN);

endmodule

// File: tb/tb_rst_sequencer.sv
// Bench for rst_sequencer: expected per-edge outputs are queued as stimulus is driven
// and popped/compared 1ns after each rising edge (or immediately for async reset).
module tb_rst_sequencer;

   typedef struct {
      logic       hold;
      logic       sw;
      logic [2:0] rst;
      logic       busy;
      logic       done;
      logic [1:0] state;
   } vec_t;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       sw_rst_req_i = 1'b0;
   logic       hold_i = 1'b0;
   logic [2:0] rst_o;
   logic       busy_o;
   logic       done_o;
   logic [1:0] state_o;

   int checks = 0;
   int errors = 0;
   int step   = 0;
   vec_t exp_q[$];
   vec_t t1[17];

   rst_sequencer #(
      .NUM_STAGES(3),
      .SYNC_DEPTH(2),
      .STAGE_DLY (4),
      .SW_PULSE  (8)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .sw_rst_req_i(sw_rst_req_i),
      .hold_i      (hold_i),
      .rst_o       (rst_o),
      .busy_o      (busy_o),
      .done_o      (done_o),
      .state_o     (state_o)
   );

   always #5 clk = ~clk;

   function automatic vec_t mk(input logic hold, input logic sw, input logic [2:0] rst,
                               input logic busy, input logic done, input logic [1:0] state);
      vec_t v;
      v.hold = hold; v.sw = sw; v.rst = rst; v.busy = busy; v.done = done; v.state = state;
      return v;
   endfunction

   // Outputs after n edges spent counting in RELEASE (n=0: the edge that entered it).
   function automatic vec_t rel_exp(input int n);
      vec_t v;
      int rel;
      logic [2:0] ones;
      ones = 3'b111;
      rel = n / 4;
      if (rel > 3) rel = 3;
      v.hold  = 1'b0;
      v.sw    = 1'b0;
      v.rst   = ones << rel;
      v.busy  = (rel != 3);
      v.done  = (n == 12);
      v.state = (rel == 3) ? 2'd2 : 2'd1;
      return v;
   endfunction

   task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s step %0d: got %0h expected %0h", name, step, act, exp);
      end
   endtask

   task automatic check_now();
      vec_t e;
      step++;
      if (exp_q.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL scoreboard step %0d: got empty queue expected entry", step);
      end else begin
         e = exp_q.pop_front();
         chk("rst_o",   {1'b0, rst_o}, {1'b0, e.rst});
         chk("busy_o",  {3'b0, busy_o}, {3'b0, e.busy});
         chk("done_o",  {3'b0, done_o}, {3'b0, e.done});
         chk("state_o", {2'b0, state_o}, {2'b0, e.state});
         $display("step %0d t=%0t hold=%b sw=%b rst_o=%b busy=%b done=%b state=%0d",
                  step, $time, e.hold, e.sw, rst_o, busy_o, done_o, state_o);
      end
   endtask

   task automatic apply(input vec_t v);
      hold_i       = v.hold;
      sw_rst_req_i = v.sw;
      exp_q.push_back(v);
      @(posedge clk);
      #1;
      check_now();
   endtask

   task automatic assert_reset();
      reset = 1'b1;
      exp_q.push_back(mk(hold_i, 1'b0, 3'b111, 1'b1, 1'b0, 2'd0));
      #1;
      check_now();
   endtask

   task automatic release_reset();
      @(negedge clk);
      #2;
      reset = 1'b0;
   endtask

   task automatic release_seq(input int hold_from, input int hold_len, input int stop_m);
      int m = 0;
      int h = hold_len;
      vec_t v;
      while (m < stop_m) begin
         if (m == hold_from && h > 0) begin
            v = rel_exp(m);
            v.hold = 1'b1;
            h--;
         end else begin
            m++;
            v = rel_exp(m);
         end
         apply(v);
      end
   endtask

   task automatic swrst_edges(input int n);
      for (int i = 0; i < n; i++) apply(mk(1'b0, 1'b0, 3'b111, 1'b1, 1'b0, 2'd3));
   endtask

   task automatic sw_pulse();
      apply(mk(1'b0, 1'b1, 3'b111, 1'b1, 1'b0, 2'd3));
   endtask

   task automatic run_table();
      for (int i = 0; i < 17; i++) apply(t1[i]);
   endtask

   initial begin
      // Power-on table: two sync-chain edges, entry edge 3, releases at 7/11/15.
      for (int e = 1; e <= 17; e++) begin
         if (e <= 2) t1[e-1] = mk(1'b0, 1'b0, 3'b111, 1'b1, 1'b0, 2'd0);
         else        t1[e-1] = rel_exp(e - 3);
      end

      // Power-on release with reset held 20ns, dropped mid-cycle
      #1;
      assert_reset();
      #18;
      release_reset();
      run_table();

      // Software reset from RUN
      sw_pulse();
      swrst_edges(7);
      apply(rel_exp(0));
      release_seq(-1, 0, 13);

      // Software request on the final-release edge, then a restart inside SWRST
      sw_pulse();
      swrst_edges(7);
      apply(rel_exp(0));
      release_seq(-1, 0, 11);
      sw_pulse();
      swrst_edges(3);
      sw_pulse();
      swrst_edges(7);
      apply(rel_exp(0));

      // Hold for 6 cycles right after stage 0 release
      release_seq(4, 6, 13);

      // Hold through board reset release until edge 20
      sw_rst_req_i = 1'b0;
      hold_i       = 1'b1;
      #2;
      assert_reset();
      #10;
      release_reset();
      for (int e = 1; e <= 20; e++) apply(mk(1'b1, 1'b0, 3'b111, 1'b1, 1'b0, 2'd0));
      apply(rel_exp(0));
      release_seq(-1, 0, 9);

      // Async reset mid-RELEASE (rst_o=100), then a full repeat of the power-on sequence
      #2;
      hold_i = 1'b0;
      assert_reset();
      #10;
      release_reset();
      run_table();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
